// File: rtl/qs_pkg.sv
// Shared types for the qs egress stage: write-FSM states, buffer entry layout
// and a saturating counter helper.
package qs_pkg;

  localparam int W = 32;

  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,
    WS_PKT  = 2'd1,
    WS_DROP = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic         err;
    logic [W-1:0] dat;
  } qs_entry_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/qs_egress_fifo.sv
// Plain circular buffer: push at tail, pop at head, head entry always visible.
// Latency 1 cycle push-to-head; caller guarantees no push when full, no pop when empty.
module qs_egress_fifo #(
  parameter int DW    = 35,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_dat,
  input  logic                       pop,
  output logic [DW-1:0]              head_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/qs_egress.sv
// Egress packet buffer for sorted qs beats: admits whole packets when space allows,
// truncates on overflow or mid-packet sop, flags order violations, counts packets/drops.
module qs_egress
  import qs_pkg::*;
#(
  parameter int W     = qs_pkg::W,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic          in_err,
  input  logic [W-1:0]  in_dat,
  output logic          out_vld,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_err,
  output logic [W-1:0]  out_dat,
  input  logic          out_rdy,
  output logic [15:0]   stat_pkt_r,
  output logic [15:0]   stat_drop_r
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wr_state_e    state_q, state_d;
  logic [W-1:0] prev_q, prev_d;
  logic [15:0]  stat_pkt_q, stat_pkt_d;
  logic [15:0]  stat_drop_q, stat_drop_d;

  logic          push;
  logic          pop;
  qs_entry_t     wr_entry;
  qs_entry_t     head;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          ord_viol;
  logic          pkt_inc;
  logic          drop_inc;

  // Free space deliberately ignores a pop in the same cycle.
  assign free     = DEPTH_C - count;
  assign ord_viol = !in_sop && (in_dat < prev_q);

  always_comb begin
    state_d      = state_q;
    push         = 1'b0;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    wr_entry.sop = in_sop;
    wr_entry.eop = in_eop;
    wr_entry.err = in_err | ord_viol;
    wr_entry.dat = in_dat;
    if (in_vld) begin
      unique case (state_q)
        WS_IDLE: begin
          if (in_sop) begin
            if ((in_eop && free >= CW'(1)) || (!in_eop && free >= CW'(2))) begin
              push    = 1'b1;
              pkt_inc = in_eop;
              state_d = in_eop ? WS_IDLE : WS_PKT;
            end else begin
              drop_inc = 1'b1;
              state_d  = in_eop ? WS_IDLE : WS_DROP;
            end
          end
        end
        WS_PKT: begin
          if (in_sop) begin
            // Close the open packet on this beat; the new packet is lost.
            push         = 1'b1;
            wr_entry.sop = 1'b0;
            wr_entry.eop = 1'b1;
            wr_entry.err = 1'b1;
            pkt_inc      = 1'b1;
            drop_inc     = 1'b1;
            state_d      = in_eop ? WS_IDLE : WS_DROP;
          end else if (in_eop || free >= CW'(2)) begin
            push    = 1'b1;
            pkt_inc = in_eop;
            state_d = in_eop ? WS_IDLE : WS_PKT;
          end else begin
            // Last free slot: truncate so the buffered packet still terminates.
            push         = 1'b1;
            wr_entry.eop = 1'b1;
            wr_entry.err = 1'b1;
            pkt_inc      = 1'b1;
            drop_inc     = 1'b1;
            state_d      = WS_DROP;
          end
        end
        WS_DROP: begin
          if (in_eop) begin
            state_d = WS_IDLE;
          end
        end
        default: state_d = WS_IDLE;
      endcase
    end
    prev_d      = push ? in_dat : prev_q;
    stat_pkt_d  = sat_inc(stat_pkt_q, pkt_inc);
    stat_drop_d = sat_inc(stat_drop_q, drop_inc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WS_IDLE;
      prev_q      <= '0;
      stat_pkt_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      stat_pkt_q  <= stat_pkt_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  qs_egress_fifo #(
    .DW    ($bits(qs_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (wr_entry),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  assign out_vld     = (count != '0);
  assign pop         = out_vld & out_rdy;
  assign out_sop     = head.sop;
  assign out_eop     = head.eop;
  assign out_err     = head.err;
  assign out_dat     = head.dat;
  assign stat_pkt_r  = stat_pkt_q;
  assign stat_drop_r = stat_drop_q;

endmodule

// File: tb/tb_qs_egress.sv
// Directed per-cycle vector bench for qs_egress (W=32, DEPTH=4).
module tb_qs_egress;

  logic        clk;
  logic        rst;
  logic        in_vld, in_sop, in_eop, in_err;
  logic [31:0] in_dat;
  logic        out_vld, out_sop, out_eop, out_err;
  logic [31:0] out_dat;
  logic        out_rdy;
  logic [15:0] stat_pkt_r, stat_drop_r;

  int n_chk;
  int n_pass;

  qs_egress #(.W(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_err      (in_err),
    .in_dat      (in_dat),
    .out_vld     (out_vld),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_err     (out_err),
    .out_dat     (out_dat),
    .out_rdy     (out_rdy),
    .stat_pkt_r  (stat_pkt_r),
    .stat_drop_r (stat_drop_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld, sop, eop, err;
    logic [31:0] dat;
    logic        rdy;
    logic        e_vld, e_sop, e_eop, e_err;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic vld, sop, eop, err, input logic [31:0] dat,
                              input logic rdy, input logic ev, es, ee, er,
                              input logic [31:0] ed);
    vec_t v;
    v.vld = vld; v.sop = sop; v.eop = eop; v.err = err; v.dat = dat; v.rdy = rdy;
    v.e_vld = ev; v.e_sop = es; v.e_eop = ee; v.e_err = er; v.e_dat = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Apply each vector before a rising edge and check outputs just after it.
  task automatic run_vq(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      in_vld = vq[i].vld; in_sop = vq[i].sop; in_eop = vq[i].eop;
      in_err = vq[i].err; in_dat = vq[i].dat; out_rdy = vq[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].vld", tag, i), 64'(out_vld), 64'(vq[i].e_vld));
      if (vq[i].e_vld)
        chk($sformatf("%s[%0d].beat", tag, i),
            64'({out_sop, out_eop, out_err, out_dat}),
            64'({vq[i].e_sop, vq[i].e_eop, vq[i].e_err, vq[i].e_dat}));
    end
    vq.delete();
  endtask

  task automatic chk_stats(input string tag, input logic [15:0] p, input logic [15:0] d);
    chk({tag, ".stat_pkt"}, 64'(stat_pkt_r), 64'(p));
    chk({tag, ".stat_drop"}, 64'(stat_drop_r), 64'(d));
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b0;
    in_vld = 0; in_sop = 0; in_eop = 0; in_err = 0; in_dat = '0; out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.vld", 64'(out_vld), 64'(0));
    chk_stats("reset", 16'd0, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic packet streamed straight through.
    vq.push_back(mk(1,1,0,0,  3, 1,  1,1,0,0,  3));
    vq.push_back(mk(1,0,0,0,  5, 1,  1,0,0,0,  5));
    vq.push_back(mk(1,0,1,0,  9, 1,  1,0,1,0,  9));
    vq.push_back(mk(0,0,0,0,  0, 1,  0,0,0,0,  0));
    run_vq("pkt3");
    chk_stats("pkt3", 16'd1, 16'd0);

    // Descending data inside a packet flags the second beat.
    vq.push_back(mk(1,1,0,0,  7, 1,  1,1,0,0,  7));
    vq.push_back(mk(1,0,1,0,  2, 1,  1,0,1,1,  2));
    vq.push_back(mk(0,0,0,0,  0, 1,  0,0,0,0,  0));
    run_vq("order");
    chk_stats("order", 16'd2, 16'd0);

    // Stalled output: 6-beat packet truncated at beat 4.
    for (int b = 1; b <= 6; b++)
      vq.push_back(mk(1, b == 1, b == 6, 0, 32'(b), 0,  1,1,0,0, 1));
    vq.push_back(mk(0,0,0,0, 0, 1,  1,0,0,0, 2));
    vq.push_back(mk(0,0,0,0, 0, 1,  1,0,0,0, 3));
    vq.push_back(mk(0,0,0,0, 0, 1,  1,0,1,1, 4));
    vq.push_back(mk(0,0,0,0, 0, 1,  0,0,0,0, 0));
    run_vq("trunc");
    chk_stats("trunc", 16'd3, 16'd1);

    // Fill exactly, reject a packet while full, drain, then accept again.
    for (int b = 1; b <= 4; b++)
      vq.push_back(mk(1, b == 1, b == 4, 0, 32'(b), 0,  1,1,0,0, 1));
    vq.push_back(mk(1,1,0,0, 50, 0,  1,1,0,0, 1));
    vq.push_back(mk(1,0,1,0, 51, 0,  1,1,0,0, 1));
    vq.push_back(mk(0,0,0,0,  0, 1,  1,0,0,0, 2));
    vq.push_back(mk(0,0,0,0,  0, 1,  1,0,0,0, 3));
    vq.push_back(mk(0,0,0,0,  0, 1,  1,0,1,0, 4));
    vq.push_back(mk(0,0,0,0,  0, 1,  0,0,0,0, 0));
    vq.push_back(mk(1,1,1,0, 60, 1,  1,1,1,0, 60));
    vq.push_back(mk(0,0,0,0,  0, 1,  0,0,0,0, 0));
    run_vq("full");
    chk_stats("full", 16'd5, 16'd2);

    // sop arriving mid-packet closes the open packet on that beat.
    vq.push_back(mk(1,1,0,0, 10, 1,  1,1,0,0, 10));
    vq.push_back(mk(1,0,0,0, 20, 1,  1,0,0,0, 20));
    vq.push_back(mk(1,1,0,0, 30, 1,  1,0,1,1, 30));
    vq.push_back(mk(1,0,1,0, 40, 1,  0,0,0,0,  0));
    vq.push_back(mk(0,0,0,0,  0, 1,  0,0,0,0,  0));
    run_vq("midsop");
    chk_stats("midsop", 16'd6, 16'd3);

    // Reset in the middle of a packet.
    vq.push_back(mk(1,1,0,0, 100, 0,  1,1,0,0, 100));
    vq.push_back(mk(1,0,0,0, 101, 0,  1,1,0,0, 100));
    run_vq("rstmid");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid.vld_async", 64'(out_vld), 64'(0));
    chk_stats("rstmid.async", 16'd0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    vq.push_back(mk(1,0,0,0, 102, 1,  0,0,0,0, 0));
    vq.push_back(mk(1,0,1,0, 103, 1,  0,0,0,0, 0));
    vq.push_back(mk(0,0,0,0,   0, 1,  0,0,0,0, 0));
    run_vq("postrst");
    chk_stats("postrst", 16'd0, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qs_egress.md
QS_EGRESS -- requirements
Module: qs_egress

Interface
REQ-001 Parameter W, qs_pkg::W, data beat width.
REQ-002 Parameter DEPTH, 16, buffer entries; power of two, >= 4.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_vld / in_sop / in_eop / in_err  in  1 each  sorted beat from qs output; no backpressure.
REQ-006 in_dat  in  W  sorted beat data.
REQ-007 out_vld / out_sop / out_eop / out_err  out  1 each  egress beat qualifiers.
REQ-008 out_dat  out  W  egress beat data.
REQ-009 out_rdy  in  1  downstream accepts beat when out_vld & out_rdy.
REQ-010 stat_pkt_r  out  16  packets written (including truncated), saturating.
REQ-011 stat_drop_r  out  16  packets dropped or truncated, saturating.

Function
REQ-012 Write FSM states: IDLE, PKT, DROP; free = DEPTH - count_r (registered count; same-cycle pop ignored).
REQ-013 IDLE, in_vld & in_sop: in_eop & free>=1 or !in_eop & free>=2 -> write beat, go PKT (stay IDLE if in_eop); else discard, stat_drop+1, go DROP (stay IDLE if in_eop).
REQ-014 IDLE, in_vld & !in_sop: discard silently, no counter change.
REQ-015 PKT, !in_sop, in_eop or free>=2: write beat; in_eop -> IDLE, stat_pkt+1.
REQ-016 PKT, !in_sop, !in_eop, free==1: write beat with eop=1, err=1; stat_pkt+1, stat_drop+1; go DROP.
REQ-017 PKT, in_sop: write beat with sop=0, eop=1, err=1 (closes prior packet; new packet lost); stat_pkt+1, stat_drop+1; go IDLE if in_eop else DROP.
REQ-018 DROP: discard all beats; in_eop -> IDLE.
REQ-019 Written err = in_err | order violation | truncation; order violation = non-sop beat with in_dat < previous written in_dat (unsigned).
REQ-020 Order reference register updated on every written beat; sop beat never flags order violation.
REQ-021 Read side: out_vld = count_r != 0; out_* driven from head entry; pop on out_vld & out_rdy.
REQ-022 Latency: beat written in cycle N presented on out_* in cycle N+1 at earliest.
REQ-023 Simultaneous push and pop: count_r unchanged; pointers wrap modulo DEPTH.
REQ-024 Buffer never overflows; pop on empty impossible (out_vld low).
REQ-025 Counters saturate at 16'hFFFF; REQ-016/017 increment both in one cycle.

Reset
REQ-026 While rst low: count_r, pointers, order register = 0; FSM = IDLE; out_vld = 0; stat_pkt_r = stat_drop_r = 0.
REQ-027 out_sop/out_eop/out_err/out_dat don't-care while out_vld = 0.
REQ-028 Reset mid-packet flushes buffer; after release non-sop beats discarded per REQ-014 until next in_sop.

Structure
REQ-029 qs_pkg holds write-FSM state enum and entry struct {sop, eop, err, dat[W]}.
REQ-030 One sub-module, qs_egress_fifo: storage, pointers, count_r; push/pop, head read; no packet awareness.
REQ-031 qs_egress holds FSM, order check, counters; no other hierarchy.

Verification (W=32, DEPTH=4)
REQ-032 Packet {3,5,9}, out_rdy=1 -> 3 beats out from cycle N+1, sop on 3, eop on 9, err=0; stat_pkt=1.
REQ-033 Packet {7,2} -> beat 2 err=1, beat 1 err=0; stat_pkt=1, stat_drop=0.
REQ-034 out_rdy=0, 6-beat packet {1..6} -> buffer holds 1,2,3,4 with 4 marked eop=1 err=1; 5,6 discarded; stat_pkt=1, stat_drop=1.
REQ-035 Buffer full (4 entries), new 2-beat packet -> both beats discarded, count stays 4, stat_drop+1; after drain, next packet accepted.
REQ-036 in_sop mid-packet {10,20,sop 30,40 eop} -> output 10,20,30 with 30 eop=1 err=1 sop=0; 40 discarded; stat_pkt=1, stat_drop=1.
REQ-037 rst low after 2 of 4 beats -> out_vld=0 immediately; after release remaining 2 beats discarded; counters 0.
